apb4_mem_slave: RTL and testbench

- Parametrised successor to the team's APB memory slave: APB4 slave backed by a word-addressed register-file memory.
- Adds configurable wait states, byte write strobes (pstrb), error response on out-of-range or misaligned addresses, and abort on protocol violation.
- Sits behind the APB interconnect as a generic scratch/config memory; it is the DUT for the APB bench family.

---
 rtl/apb4_mem_slave.sv | 119 +++++++++++
 tb/tb_apb4_mem_slave.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/apb4_mem_slave.sv
// APB4 slave backed by a word-addressed register-file memory.
// Supports configurable wait states, byte strobes, error responses and abort on protocol violation.
module apb4_mem_slave #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MEM_DEPTH   = 128,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic                    pclk_i,
   input  logic                    preset_i,
   input  logic                    psel_i,
   input  logic                    penable_i,
   input  logic                    pwrite_i,
   input  logic [ADDR_WIDTH-1:0]   paddr_i,
   input  logic [DATA_WIDTH-1:0]   pwdata_i,
   input  logic [DATA_WIDTH/8-1:0] pstrb_i,
   output logic [DATA_WIDTH-1:0]   prdata_o,
   output logic                    pready_o,
   output logic                    pslverr_o
);

   localparam int unsigned NumBytes = DATA_WIDTH / 8;
   localparam int unsigned OffW     = $clog2(NumBytes);
   localparam int unsigned MemAw    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] OffMask = ADDR_WIDTH'((1 << OffW) - 1);

   typedef enum logic {StIdle, StAccess} state_e;

   state_e                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    write_q, write_d;
   logic                    err_q, err_d;

   logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

   logic [ADDR_WIDTH-1:0]   setup_idx;
   logic                    setup_err;
   logic [MemAw-1:0]        mem_idx;
   logic                    access_hs;
   logic                    done;
   logic                    mem_we;

   assign setup_idx = paddr_i >> OffW;
   assign setup_err = (|(paddr_i & OffMask)) || (32'(setup_idx) >= MEM_DEPTH);
   // Only meaningful when err_q is clear, i.e. the latched index is in range.
   assign mem_idx   = addr_q[OffW +: MemAw];
   assign access_hs = (state_q == StAccess) && psel_i && penable_i;
   assign done      = access_hs && (cnt_q == 4'd0);
   assign mem_we    = done && write_q && !err_q;

   always_ff @(posedge pclk_i or posedge preset_i) begin
      if (preset_i) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (psel_i && !penable_i) begin
               addr_d  = paddr_i;
               write_d = pwrite_i;
               err_d   = setup_err;
               cnt_d   = 4'(WAIT_STATES);
               state_d = StAccess;
            end
         end
         StAccess: begin
            // Dropping psel or penable before completion abandons the transfer.
            if (!access_hs || (cnt_q == 4'd0)) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      pready_o  = 1'b0;
      pslverr_o = 1'b0;
      prdata_o  = '0;
      if ((state_q == StAccess) && (cnt_q == 4'd0)) begin
         pready_o  = 1'b1;
         pslverr_o = err_q;
         if (!write_q && !err_q) begin
            prdata_o = mem_q[mem_idx];
         end
      end
   end

   always_ff @(posedge pclk_i) begin
      if (mem_we && !preset_i) begin
         for (int i = 0; i < NumBytes; i++) begin
            if (pstrb_i[i]) begin
               mem_q[mem_idx][8*i +: 8] <= pwdata_i[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Self-checking bench: two slaves (WAIT_STATES=2 and 0) on a shared bus, checked against a word model.
module tb_apb4_mem_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [9:0]  paddr = '0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;

   logic        psel0, psel1;
   logic [31:0] prdata0, prdata1, prdata;
   logic        pready0, pready1, pready;
   logic        perr0, perr1, pslverr;

   logic [31:0] mem [2][128];
   logic [31:0] last_rd = '0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   assign psel0   = psel & ~sel;
   assign psel1   = psel & sel;
   assign prdata  = sel ? prdata1 : prdata0;
   assign pready  = sel ? pready1 : pready0;
   assign pslverr = sel ? perr1 : perr0;

   apb4_mem_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(128), .WAIT_STATES(2)) u_dut0 (
      .pclk_i(clk), .preset_i(rst), .psel_i(psel0), .penable_i(penable), .pwrite_i(pwrite),
      .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
      .prdata_o(prdata0), .pready_o(pready0), .pslverr_o(perr0)
   );

   apb4_mem_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(128), .WAIT_STATES(0)) u_dut1 (
      .pclk_i(clk), .preset_i(rst), .psel_i(psel1), .penable_i(penable), .pwrite_i(pwrite),
      .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
      .prdata_o(prdata1), .pready_o(pready1), .pslverr_o(perr1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit addr_err(input logic [9:0] a);
      return (a[1:0] != 2'd0) || ((a >> 2) >= 10'd128);
   endfunction

   // Called #1 after a rising edge; returns #1 after the completion (or abort) edge.
   task automatic xfer(input bit wr, input logic [9:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int abort_at);
      int          ws;
      bit          e;
      bit          rdy;
      logic [31:0] exp_rd;
      ws = sel ? 0 : 2;
      e  = addr_err(a);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
      @(negedge clk);
      check("setup_pready", {31'd0, pready}, 32'd0);
      check("setup_prdata", prdata, 32'd0);
      @(posedge clk); #1;
      for (int c = 1; c <= ws + 1; c++) begin
         penable = 1'b1;
         // Address/direction must be ignored once latched.
         paddr  = 10'($urandom);
         pwrite = 1'($urandom);
         if (c == abort_at) psel = 1'b0;
         @(negedge clk);
         rdy    = (c == ws + 1);
         exp_rd = '0;
         if (rdy && !wr && !e) exp_rd = mem[sel][a[9:2]];
         check("pready", {31'd0, pready}, {31'd0, rdy});
         check("pslverr", {31'd0, pslverr}, {31'd0, rdy && e});
         check("prdata", prdata, exp_rd);
         if (rdy && !wr) last_rd = prdata;
         @(posedge clk); #1;
         if (c == abort_at) begin
            penable = 1'b0;
            return;
         end
      end
      if (wr && !e) begin
         for (int b = 0; b < 4; b++) begin
            if (s[b]) mem[sel][a[9:2]][8*b +: 8] = d[8*b +: 8];
         end
      end
   endtask

   task automatic idle();
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      check("idle_pready", {31'd0, pready}, 32'd0);
      check("idle_pslverr", {31'd0, pslverr}, 32'd0);
      check("idle_prdata", prdata, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] old;
      logic [9:0]  a;
      // Reset with random bus activity on both slaves.
      for (int i = 0; i < 3; i++) begin
         psel = 1'($urandom); penable = 1'($urandom); pwrite = 1'($urandom);
         paddr = 10'($urandom); pwdata = $urandom; pstrb = 4'($urandom);
         @(negedge clk);
         check("rst_out0", {prdata0[30:0] | {30'd0, pready0}, perr0}, 32'd0);
         check("rst_out1", {prdata1[30:0] | {30'd0, pready1}, perr1}, 32'd0);
         check("rst_msb", {30'd0, prdata0[31], prdata1[31]}, 32'd0);
         @(posedge clk); #1;
      end
      psel = 1'b0; penable = 1'b0; rst = 1'b0;
      idle();

      // Fill both memories so every later read has a known value.
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         for (int i = 0; i < 128; i++) xfer(1'b1, 10'(i * 4), $urandom, 4'hF, 0);
         idle();
      end
      sel = 1'b0;

      xfer(1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 0); idle();
      xfer(1'b0, 10'h010, 32'h0, 4'h0, 0); idle();
      check("wr_rd_deadbeef", last_rd, 32'hDEADBEEF);

      xfer(1'b1, 10'h020, 32'h11223344, 4'hF, 0); idle();
      xfer(1'b1, 10'h020, 32'hAABBCCDD, 4'b0101, 0); idle();
      xfer(1'b0, 10'h020, 32'h0, 4'h0, 0); idle();
      check("strb_merge", last_rd, 32'h11BB33DD);
      xfer(1'b1, 10'h020, 32'hFFFFFFFF, 4'h0, 0); idle();
      xfer(1'b0, 10'h020, 32'h0, 4'h0, 0); idle();
      check("strb_zero", last_rd, 32'h11BB33DD);

      xfer(1'b1, 10'h200, 32'h12345678, 4'hF, 0); idle();
      xfer(1'b0, 10'h200, 32'h0, 4'h0, 0); idle();
      xfer(1'b0, 10'h012, 32'h0, 4'h0, 0); idle();
      xfer(1'b0, 10'h000, 32'h0, 4'h0, 0); idle();

      old = mem[0][12];
      xfer(1'b1, 10'h030, ~old, 4'hF, 2); idle();
      xfer(1'b0, 10'h030, 32'h0, 4'h0, 0); idle();
      check("abort_keeps_old", last_rd, old);

      // Reset during a write's wait cycle.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h030; pwdata = ~old; pstrb = 4'hF;
      @(posedge clk); #1; penable = 1'b1;
      @(negedge clk); rst = 1'b1; #1;
      check("rstw_out", {prdata[30:0] | {30'd0, pready}, pslverr}, 32'd0);
      repeat (2) @(posedge clk);
      #1; psel = 1'b0; penable = 1'b0; rst = 1'b0;
      idle();
      xfer(1'b0, 10'h030, 32'h0, 4'h0, 0); idle();
      check("rst_write_dropped", last_rd, old);

      // Reset on a read's completion cycle clears prdata at once.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 10'h010;
      @(posedge clk); #1; penable = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rstr_before", prdata, mem[0][4]);
      rst = 1'b1; #1;
      check("rstr_prdata", prdata, 32'd0);
      check("rstr_pready", {31'd0, pready}, 32'd0);
      repeat (2) @(posedge clk);
      #1; psel = 1'b0; penable = 1'b0; rst = 1'b0;
      idle();

      // Random traffic, including misaligned and out-of-range addresses.
      for (int i = 0; i < 40; i++) begin
         a = 10'($urandom_range(0, 10'h27F));
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'd0;
         xfer(1'($urandom), a, $urandom, 4'($urandom), 0);
         if ($urandom_range(0, 1) != 0) idle();
      end
      idle();

      // Zero-wait slave, back-to-back write/read pairs.
      sel = 1'b1;
      for (int i = 0; i < 5; i++) begin
         a = {1'b0, 7'($urandom), 2'd0};
         old = $urandom;
         xfer(1'b1, a, old, 4'hF, 0);
         xfer(1'b0, a, 32'h0, 4'h0, 0);
         check("b2b_rd", last_rd, old);
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
